// File: rtl/delay_line_pkg.sv
// Shared constants and sizing helper for the delay line block.
package delay_line_pkg;

  localparam int DEFAULT_DELAY       = 64;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_LED_STRETCH = 4194304;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/delay_line_top_pulse_stretcher.sv
// Rising-edge detector feeding a retriggerable down-counter; output is high
// while the counter is non-zero.
module pulse_stretcher #(
  parameter int LENGTH = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic pulse_o
);
  import delay_line_pkg::*;

  localparam int CW = cnt_width(LENGTH);
  localparam logic [CW-1:0] RELOAD = CW'(LENGTH);

  logic          prev_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          rise;

  // A fresh rising edge always wins over the decrement, so overlapping pulses merge.
  always_comb begin
    rise    = sig_i & ~prev_q;
    count_d = count_q;
    if (rise) begin
      count_d = RELOAD;
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q  <= 1'b0;
      count_q <= '0;
    end else begin
      prev_q  <= sig_i;
      count_q <= count_d;
    end
  end

  assign pulse_o = (count_q != '0);

endmodule

// File: rtl/delay_line_top.sv
// Synchronises an asynchronous input and replays it DELAY cycles later via a
// circular buffer, with stretched activity LEDs on input and output.
module delay_line_top #(
  parameter int DELAY       = delay_line_pkg::DEFAULT_DELAY,
  parameter int SYNC_STAGES = delay_line_pkg::DEFAULT_SYNC_STAGES,
  parameter int LED_STRETCH = delay_line_pkg::DEFAULT_LED_STRETCH
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic in,
  output logic led0,
  output logic led1,
  output logic out
);
  import delay_line_pkg::*;

  localparam int PW = cnt_width(DELAY - 1);
  localparam int FW = cnt_width(DELAY);
  localparam logic [PW-1:0] PTR_LAST = PW'(DELAY - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DELAY);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [DELAY-1:0]       mem_q;
  logic [PW-1:0]          ptr_q;
  logic [PW-1:0]          ptr_d;
  logic [FW-1:0]          fill_q;
  logic [FW-1:0]          fill_d;
  logic                   fill_full;
  logic                   out_q;
  logic                   out_d;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign fill_full = (fill_q == FILL_MAX);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  // Output stays masked until every buffer entry has been written since reset.
  always_comb begin
    ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
    fill_d = fill_full ? fill_q : fill_q + FW'(1);
    out_d  = fill_full ? mem_q[ptr_q] : 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr_q  <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      fill_q <= fill_d;
      out_q  <= out_d;
    end
  end

  // Storage is never reset; the fill mask hides whatever it held before.
  always_ff @(posedge clk_in) begin
    mem_q[ptr_q] <= sync_out;
  end

  assign out = out_q;

  pulse_stretcher #(
    .LENGTH (LED_STRETCH)
  ) u_led0_stretch (
    .clk_i   (clk_in),
    .rst_ni  (rst_n_in),
    .sig_i   (sync_out),
    .pulse_o (led0)
  );

  pulse_stretcher #(
    .LENGTH (LED_STRETCH)
  ) u_led1_stretch (
    .clk_i   (clk_in),
    .rst_ni  (rst_n_in),
    .sig_i   (out_q),
    .pulse_o (led1)
  );

endmodule

// File: tb/tb_delay_line_top.sv
// Self-checking bench for delay_line_top: a 64-deep and a 5-deep instance
// share stimulus and are compared against a latency model and hand tables.
module tb_delay_line_top;

  localparam int S    = 2;
  localparam int LEN  = 16;
  localparam int D64  = 64;
  localparam int D5   = 5;
  localparam int L64  = S + D64;
  localparam int L5   = S + D5;
  localparam int MAXC = 10400;

  logic clock = 1'b0;
  logic resetN = 1'b0;
  logic dataIn = 1'b0;
  logic out64, led0a, led1a;
  logic out5, led0b, led1b;

  int checks = 0;
  int errors = 0;
  int edgeCount = 0;
  logic inHist [0:MAXC];

  typedef struct {
    int   atEdge;
    logic o64;
    logic o5;
    logic l0;
    logic l1a;
    logic l1b;
  } vec_t;

  vec_t vecs [14];

  always #5 clock = ~clock;

  delay_line_top #(.DELAY(D64), .SYNC_STAGES(S), .LED_STRETCH(LEN)) u_d64 (
    .clk_in(clock), .rst_n_in(resetN), .in(dataIn),
    .led0(led0a), .led1(led1a), .out(out64)
  );

  delay_line_top #(.DELAY(D5), .SYNC_STAGES(S), .LED_STRETCH(LEN)) u_d5 (
    .clk_in(clock), .rst_n_in(resetN), .in(dataIn),
    .led0(led0b), .led1(led1b), .out(out5)
  );

  // Input sampled at edge j (j>=1 since reset release); zero otherwise.
  function automatic logic inAt(input int j);
    if (j >= 1 && j <= MAXC) return inHist[j];
    return 1'b0;
  endfunction

  function automatic logic riseAt(input int j);
    return inAt(j) & ~inAt(j - 1);
  endfunction

  function automatic logic riseWithin(input int lo, input int hi);
    logic r = 1'b0;
    for (int j = lo; j <= hi; j++) r |= riseAt(j);
    return r;
  endfunction

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %b expected %b", name, edgeCount, act, exp);
    end
  endtask

  task automatic checkOutput();
    int k = edgeCount;
    checkBit("out64", out64, inAt(k - L64));
    checkBit("led0_64", led0a, riseWithin(k - S - LEN + 1, k - S));
    checkBit("led1_64", led1a, riseWithin(k - LEN - L64, k - 1 - L64));
    checkBit("out5", out5, inAt(k - L5));
    checkBit("led0_5", led0b, riseWithin(k - S - LEN + 1, k - S));
    checkBit("led1_5", led1b, riseWithin(k - LEN - L5, k - 1 - L5));
  endtask

  task automatic checkAllZero(input string tag);
    checkBit({tag, "_out64"}, out64, 1'b0);
    checkBit({tag, "_led0_64"}, led0a, 1'b0);
    checkBit({tag, "_led1_64"}, led1a, 1'b0);
    checkBit({tag, "_out5"}, out5, 1'b0);
    checkBit({tag, "_led0_5"}, led0b, 1'b0);
    checkBit({tag, "_led1_5"}, led1b, 1'b0);
  endtask

  // One clock: drive input, take the edge, record it, settle to the negedge.
  task automatic applyStimulus(input logic v);
    dataIn = v;
    @(posedge clock);
    edgeCount++;
    if (edgeCount <= MAXC) inHist[edgeCount] = v;
    @(negedge clock);
  endtask

  task automatic doReset(input logic inDuringRelease);
    resetN = 1'b0;
    for (int i = 0; i <= MAXC; i++) inHist[i] = 1'b0;
    edgeCount = 0;
    repeat (3) @(negedge clock);
    checkAllZero("reset");
    dataIn = inDuringRelease;
    resetN = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{17, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{18, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{27, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{28, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{75, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{76, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{92, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{93, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Single one-cycle pulse at edge 10, compared against the hand table.
    @(negedge clock);
    doReset(1'b0);
    for (int c = 1; c <= 100; c++) begin
      applyStimulus(c == 10);
      checkOutput();
      foreach (vecs[i]) begin
        if (vecs[i].atEdge == edgeCount) begin
          checkBit("tbl_out64", out64, vecs[i].o64);
          checkBit("tbl_out5", out5, vecs[i].o5);
          checkBit("tbl_led0", led0a, vecs[i].l0);
          checkBit("tbl_led1_64", led1a, vecs[i].l1a);
          checkBit("tbl_led1_5", led1b, vecs[i].l1b);
        end
      end
    end

    // Periodic pattern: 100 low, 10 high, 50 periods.
    doReset(1'b0);
    for (int p = 0; p < 50; p++) begin
      for (int c = 0; c < 110; c++) begin
        applyStimulus(c >= 100);
        checkOutput();
      end
    end
    repeat (L64 + 2) begin
      applyStimulus(1'b0);
      checkOutput();
    end

    // Constant high from reset release: masked for L cycles, then steady.
    doReset(1'b1);
    for (int c = 1; c <= 120; c++) begin
      applyStimulus(1'b1);
      checkOutput();
      if (c == L64) checkBit("const_out64_last_masked", out64, 1'b0);
      if (c == L64 + 1) checkBit("const_out64_first_high", out64, 1'b1);
    end

    // LED stretching: pulses 20 apart, then 8 apart.
    doReset(1'b0);
    for (int c = 1; c <= 300; c++) begin
      applyStimulus((c <= 100) ? (c % 20 == 5) : (c <= 160 && c % 8 == 0));
      checkOutput();
    end

    // Reset asserted between edges while output and LEDs are lit.
    doReset(1'b0);
    for (int c = 1; c <= 74; c++) begin
      applyStimulus((c <= 20) || (c >= 70 && c <= 72));
      checkOutput();
    end
    #2;
    resetN = 1'b0;
    #1;
    checkAllZero("async_reset");
    doReset(1'b0);
    for (int c = 1; c <= 100; c++) begin
      applyStimulus(1'b0);
      checkOutput();
    end

    // Long idle stretch with the input held low.
    doReset(1'b0);
    for (int c = 1; c <= 10000; c++) begin
      applyStimulus(1'b0);
      checkOutput();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
